// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM burst arbiter: FSM states and ID width derivation.
package rom_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Requester ID width: at least one bit even for a single requester.
  function automatic int idWidth(input int numReq);
    return (clog2(numReq) < 1) ? 1 : clog2(numReq);
  endfunction

endpackage

// File: rtl/rom_burst_arbiter_if.sv
// Bundle of request, ROM and output-stream signals between the arbiter and its surroundings.
interface rom_burst_arbiter_if
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  localparam int ID_WIDTH = idWidth(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic                          rom_rd_en;
  logic [ADDR_WIDTH-1:0]         rom_addr;
  logic [DATA_WIDTH-1:0]         rom_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_last;
  logic [ID_WIDTH-1:0]           out_id;

  // Requesters, ROM and consumer side
  modport master (
    output req_valid, req_addr, req_len, rom_data, out_ready,
    input  req_ready, rom_rd_en, rom_addr, out_valid, out_data, out_last, out_id
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_addr, req_len, rom_data, out_ready,
    output req_ready, rom_rd_en, rom_addr, out_valid, out_data, out_last, out_id
  );

endinterface

// File: rtl/rom_arb_fifo.sv
// Two-entry return FIFO holding {last, id, data} for words coming back from the ROM.
module rom_arb_fifo #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;

  // Storage, pointers and occupancy; push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (i_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter that turns burst requests into a ROM read sequence and a tagged output stream.
module rom_burst_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input logic                clk,
  input logic                rst_n,
  rom_burst_arbiter_if.slave bus
);

  localparam int ID_WIDTH   = idWidth(NUM_REQ);
  localparam int FIFO_WIDTH = 1 + ID_WIDTH + DATA_WIDTH;

  state_t                r_state;
  state_t                w_nextState;
  logic [ID_WIDTH-1:0]   r_rrPtr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ID_WIDTH-1:0]   r_inflightId;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic                  r_inflight;
  logic                  r_inflightLast;

  logic [ADDR_WIDTH-1:0] w_reqAddr [NUM_REQ];
  logic [LEN_WIDTH-1:0]  w_reqLen  [NUM_REQ];
  logic [ID_WIDTH-1:0]   w_grantIdx;
  logic [ID_WIDTH-1:0]   w_candidate;
  logic                  w_grantAny;
  logic                  w_grant;
  logic                  w_issue;
  logic                  w_lastIssue;
  logic                  w_pop;
  logic [1:0]            w_fifoCount;
  logic [2:0]            w_occupancy;
  logic [FIFO_WIDTH-1:0] w_fifoHead;

  // Unpack the flat request buses into per-requester fields.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_reqAddr[i] = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_reqLen[i]  = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  // Pick the first valid requester at or after the round-robin pointer; scanning downwards lets the closest one win.
  always_comb begin
    w_grantAny  = 1'b0;
    w_grantIdx  = '0;
    w_candidate = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_candidate = ID_WIDTH'((int'(r_rrPtr) + k) % NUM_REQ);
      if (bus.req_valid[w_candidate]) begin
        w_grantAny = 1'b1;
        w_grantIdx = w_candidate;
      end
    end
  end

  // Credit: at most two words may be in flight or buffered, counting a word leaving this cycle as gone.
  assign w_pop       = bus.out_valid & bus.out_ready;
  assign w_occupancy = {2'b00, r_inflight} + {1'b0, w_fifoCount} - {2'b00, w_pop};
  assign w_grant     = (r_state == IDLE) && w_grantAny;
  assign w_issue     = (r_state == BURST) && (w_occupancy < 3'd2);
  assign w_lastIssue = w_issue && (r_remaining == '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state: a grant starts a burst, the final issue ends it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_grant)     w_nextState = BURST;
      BURST:   if (w_lastIssue) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // FSM outputs: one-cycle accept pulse and ROM read strobe, both held off while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    bus.rom_rd_en = 1'b0;
    bus.rom_addr  = r_addr;
    if (rst_n) begin
      if (w_grant) begin
        bus.req_ready[w_grantIdx] = 1'b1;
      end
      bus.rom_rd_en = w_issue;
    end
  end

  // Burst cursor, round-robin pointer and the one-deep record of the read awaiting its ROM data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rrPtr        <= '0;
      r_id           <= '0;
      r_addr         <= '0;
      r_remaining    <= '0;
      r_inflight     <= 1'b0;
      r_inflightLast <= 1'b0;
      r_inflightId   <= '0;
    end else begin
      r_inflight     <= w_issue;
      r_inflightLast <= w_lastIssue;
      r_inflightId   <= r_id;
      if (w_grant) begin
        r_addr      <= w_reqAddr[w_grantIdx];
        r_remaining <= w_reqLen[w_grantIdx];
        r_id        <= w_grantIdx;
        r_rrPtr     <= (w_grantIdx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grantIdx + ID_WIDTH'(1);
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - LEN_WIDTH'(1);
      end
    end
  end

  rom_arb_fifo #(
    .WIDTH(FIFO_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_pushData ({r_inflightLast, r_inflightId, bus.rom_data}),
    .i_pop      (w_pop),
    .o_head     (w_fifoHead),
    .o_count    (w_fifoCount)
  );

  assign bus.out_valid = (w_fifoCount != 2'd0);
  assign bus.out_last  = w_fifoHead[FIFO_WIDTH-1];
  assign bus.out_id    = w_fifoHead[DATA_WIDTH +: ID_WIDTH];
  assign bus.out_data  = w_fifoHead[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Scoreboard bench for rom_burst_arbiter: directed scenarios plus randomized traffic against a burst-level model.
module tb_rom_burst_arbiter;
  import rom_arb_pkg::*;

  localparam int NUM_REQ    = 2;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 8;
  localparam int LEN_WIDTH  = 8;
  localparam int ID_WIDTH   = idWidth(NUM_REQ);
  localparam int ROM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int WORD_W     = 1 + ID_WIDTH + DATA_WIDTH;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rom_burst_arbiter_if #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) bus ();

  rom_burst_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_WIDTH-1:0] rom [ROM_DEPTH];

  // Synchronous-read ROM with one cycle of latency.
  always @(posedge clk) begin
    if (bus.rom_rd_en) bus.rom_data <= rom[bus.rom_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [ADDR_WIDTH-1:0] expAddr [$];
  logic [WORD_W-1:0]     expWord [$];
  int  issuedCnt, lagIssued, acceptedCnt, modelRr;
  int  grantSeq [NUM_REQ];
  int  handled  [NUM_REQ];
  int  timeoutReq, timeoutAck;
  bit  prevRstN, prevStall;
  logic [WORD_W-1:0] prevWord;
  logic [WORD_W-1:0] gotWord;
  bit  mIdle, mValid, mPop, mRdEn;
  int  mOutstanding, mGrantId;
  logic [NUM_REQ-1:0] mGrantVec;
  logic [ADDR_WIDTH-1:0] mAddr, mA;
  int  mLen;
  int  readyMode, readyPhase;
  bit  holdMode;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor and reference model: bursts expand to address/word lists at grant time; the stream and credit are checked against them.
  always @(negedge clk) begin
    if (!rst_n) begin
      expAddr.delete();
      expWord.delete();
      issuedCnt   = 0;
      lagIssued   = 0;
      acceptedCnt = 0;
      modelRr     = 0;
      prevStall   = 1'b0;
    end else begin
      if (!prevRstN) begin
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_data",  bus.out_data,  0);
        checkOutput("rst_out_last",  bus.out_last,  0);
        checkOutput("rst_out_id",    bus.out_id,    0);
        checkOutput("rst_rom_rd_en", bus.rom_rd_en, 0);
        checkOutput("rst_rom_addr",  bus.rom_addr,  0);
        checkOutput("rst_req_ready", bus.req_ready, 0);
      end
      if (timeoutReq != timeoutAck) begin
        checkOutput("wait_timeout", timeoutReq, timeoutAck);
        timeoutAck = timeoutReq;
      end

      mIdle  = (expAddr.size() == 0);
      mValid = (lagIssued - acceptedCnt) > 0;
      mPop   = bus.out_valid && bus.out_ready;
      checkOutput("out_valid", bus.out_valid, mValid);

      gotWord = {bus.out_last, bus.out_id, bus.out_data};
      if (mPop) begin
        if (expWord.size() > 0) begin
          checkOutput("out_word", gotWord, expWord.pop_front());
        end else begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h expected none", gotWord);
        end
      end
      if (prevStall && bus.out_valid) checkOutput("stall_hold", gotWord, prevWord);

      mOutstanding = issuedCnt - acceptedCnt;
      mRdEn = !mIdle && ((mOutstanding - ((mValid && bus.out_ready) ? 1 : 0)) < 2);
      checkOutput("rom_rd_en", bus.rom_rd_en, mRdEn);
      if (bus.rom_rd_en && expAddr.size() > 0) checkOutput("rom_addr", bus.rom_addr, expAddr.pop_front());

      mGrantVec = '0;
      mGrantId  = 0;
      if (mIdle) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (mGrantVec == '0 && bus.req_valid[(modelRr + k) % NUM_REQ]) begin
            mGrantId  = (modelRr + k) % NUM_REQ;
            mGrantVec[mGrantId] = 1'b1;
          end
        end
      end
      checkOutput("req_ready", bus.req_ready, mGrantVec);
      if (mGrantVec != '0) begin
        mAddr = bus.req_addr[mGrantId*ADDR_WIDTH +: ADDR_WIDTH];
        mLen  = int'(bus.req_len[mGrantId*LEN_WIDTH +: LEN_WIDTH]);
        for (int b = 0; b <= mLen; b++) begin
          mA = ADDR_WIDTH'((int'(mAddr) + b) % ROM_DEPTH);
          expAddr.push_back(mA);
          expWord.push_back({(b == mLen), ID_WIDTH'(mGrantId), rom[mA]});
        end
        modelRr = (mGrantId + 1) % NUM_REQ;
        grantSeq[mGrantId]++;
      end

      lagIssued = issuedCnt;
      if (bus.rom_rd_en) issuedCnt++;
      if (mPop) acceptedCnt++;
      prevStall = bus.out_valid && !bus.out_ready;
      prevWord  = gotWord;
    end
    prevRstN = rst_n;
  end

  // Consumer readiness: always ready, a 1,0,0 repeating pattern, or random.
  initial begin
    readyPhase    = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = (readyPhase == 0);
          readyPhase    = (readyPhase + 1) % 3;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grantSeq[i] != handled[i]) begin
        handled[i] = grantSeq[i];
        if (!holdMode) bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input int id, input logic [ADDR_WIDTH-1:0] addr, input logic [LEN_WIDTH-1:0] len);
    bus.req_addr[id*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    bus.req_len[id*LEN_WIDTH +: LEN_WIDTH]    = len;
    bus.req_valid[id]                         = 1'b1;
  endtask

  task automatic applyReset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
  endtask

  task automatic waitDrain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      stepCycle();
      done = (expAddr.size() == 0) && (expWord.size() == 0) && (bus.req_valid == '0) &&
             (issuedCnt == acceptedCnt) && !bus.out_valid;
    end
    if (!done) timeoutReq++;
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    int base;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    readyMode     = 0;
    holdMode      = 1'b0;
    timeoutReq    = 0;
    timeoutAck    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grantSeq[i] = 0;
      handled[i]  = 0;
    end
    for (int i = 0; i < ROM_DEPTH; i++) rom[i] = DATA_WIDTH'($urandom);

    stepCycle();
    applyReset();

    $display("[TB] single burst");
    applyStimulus(0, 10'h010, 8'd3);
    waitDrain(200);

    $display("[TB] round robin");
    holdMode = 1'b1;
    applyStimulus(0, 10'h100, 8'd0);
    applyStimulus(1, 10'h200, 8'd0);
    repeat (12) stepCycle();
    bus.req_valid = '0;
    holdMode      = 1'b0;
    waitDrain(200);

    $display("[TB] address wrap");
    applyStimulus(1, 10'h3FE, 8'd3);
    waitDrain(200);

    $display("[TB] backpressure");
    readyMode = 1;
    applyStimulus(0, ADDR_WIDTH'($urandom), 8'd7);
    waitDrain(400);
    readyMode = 0;

    $display("[TB] reset mid-burst");
    base = issuedCnt;
    applyStimulus(0, 10'h040, 8'd7);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
        stepCycle();
        hit = (issuedCnt >= base + 3);
      end
      if (!hit) timeoutReq++;
    end
    applyReset();
    applyStimulus(1, 10'h080, 8'd1);
    applyStimulus(0, 10'h0C0, 8'd1);
    waitDrain(200);

    $display("[TB] maximum length");
    applyStimulus(0, ADDR_WIDTH'($urandom), 8'hFF);
    applyStimulus(1, ADDR_WIDTH'($urandom), 8'd2);
    waitDrain(1000);

    $display("[TB] random traffic");
    readyMode = 2;
    repeat (3000) begin
      stepCycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 5) == 0) begin
          applyStimulus(i, ADDR_WIDTH'($urandom), LEN_WIDTH'($urandom_range(0, 12)));
        end else if (bus.req_valid[i] && $urandom_range(0, 30) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
    bus.req_valid = '0;
    readyMode     = 0;
    waitDrain(2000);

    repeat (3) stepCycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
